// File: rtl/fdiv_ctrl.sv
// fdiv_ctrl: sequencer for an iterative floating-point divide datapath.
// Steps the datapath through load, ITER multiply pairs and a rounding step,
// then captures the quotient and pulses done.
module fdiv_ctrl #(
    parameter int ITER = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] n_in,
    input  logic [31:0] d_in,
    input  logic [31:0] q_in,
    output logic [31:0] N,
    output logic [31:0] D,
    output logic [1:0]  c1,
    output logic [5:0]  op,
    output logic        rm,
    output logic        busy,
    output logic        done,
    output logic [31:0] q_out
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_MUL_A  = 3'd3;
    localparam logic [2:0] S_MUL_B  = 3'd4;
    localparam logic [2:0] S_ROUND  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [3:0] ITER_LAST = 4'(ITER - 1);

    logic [2:0]  state_q, state_d;
    logic [3:0]  iter_q, iter_d;
    logic [31:0] n_q, n_d;
    logic [31:0] d_q, d_d;
    logic [31:0] qout_q, qout_d;
    logic        done_q, done_d;

    // Next-state, operand latch and quotient capture; abort overrides all.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        n_d     = n_q;
        d_d     = d_q;
        qout_d  = qout_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_A;
                    n_d     = n_in;
                    d_d     = d_in;
                end
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: begin
                state_d = S_MUL_A;
                iter_d  = 4'd0;
            end
            S_MUL_A:  state_d = S_MUL_B;
            S_MUL_B: begin
                // iter_q stays below ITER_LAST (<= 14) here, so +1 cannot wrap
                if (iter_q < ITER_LAST) begin
                    state_d = S_MUL_A;
                    iter_d  = iter_q + 4'd1;
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND:  state_d = S_DONE;
            S_DONE: begin
                state_d = S_IDLE;
                qout_d  = q_in;
                done_d  = 1'b1;
            end
            default:  state_d = S_IDLE;
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            iter_d  = iter_q;
            qout_d  = qout_q;
            done_d  = 1'b0;
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            iter_q  <= 4'd0;
            n_q     <= 32'd0;
            d_q     <= 32'd0;
            qout_q  <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            n_q     <= n_d;
            d_q     <= d_d;
            qout_q  <= qout_d;
            done_q  <= done_d;
        end
    end

    // Datapath controls decoded purely from the state register.
    always_comb begin
        c1 = 2'b00;
        op = 6'b000000;
        rm = 1'b0;
        case (state_q)
            S_LOAD_A: op = 6'b010000;
            S_LOAD_B: begin c1 = 2'b01; op = 6'b001100; end
            S_MUL_A:  begin c1 = 2'b10; op = 6'b010001; end
            S_MUL_B:  begin c1 = 2'b11; op = 6'b001101; end
            S_ROUND:  begin op = 6'b100010; rm = 1'b1; end
            default:  ;
        endcase
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign N     = n_q;
    assign D     = d_q;
    assign q_out = qout_q;

endmodule

// File: tb/tb_fdiv_ctrl.sv
// Bench for fdiv_ctrl: ITER=5 and ITER=1 builds driven by the same stimulus,
// each checked every cycle against a position-in-divide reference model.
module tb_fdiv_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] n_in = '0, d_in = '0, q_in = '0;

    logic [31:0] n_o [2];
    logic [31:0] d_o [2];
    logic [31:0] q_o [2];
    logic [1:0]  c1_o [2];
    logic [5:0]  op_o [2];
    logic        rm_o [2];
    logic        busy_o [2];
    logic        done_o [2];

    always #5 clk = ~clk;

    fdiv_ctrl #(.ITER(5)) u_dut5 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .n_in(n_in), .d_in(d_in), .q_in(q_in),
        .N(n_o[0]), .D(d_o[0]), .c1(c1_o[0]), .op(op_o[0]), .rm(rm_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .q_out(q_o[0])
    );

    fdiv_ctrl #(.ITER(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .n_in(n_in), .d_in(d_in), .q_in(q_in),
        .N(n_o[1]), .D(d_o[1]), .c1(c1_o[1]), .op(op_o[1]), .rm(rm_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .q_out(q_o[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int its [2] = '{5, 1};

    // Reference model: pos = cycles since the accepting edge, -1 when idle.
    // A divide occupies positions 0 .. 2*ITER+3.
    int          pos [2];
    logic [31:0] e_n [2], e_d [2], e_q [2];
    logic        e_done [2];
    int          dq0 [$];
    int          dq1 [$];

    function automatic logic [8:0] ctrl_exp(int p, int it);
        if (p < 0)            return 9'b0;
        if (p == 0)           return {2'b00, 6'b010000, 1'b0};
        if (p == 1)           return {2'b01, 6'b001100, 1'b0};
        if (p <= 2*it + 1)    return ((p - 2) % 2 == 0) ? {2'b10, 6'b010001, 1'b0}
                                                       : {2'b11, 6'b001101, 1'b0};
        if (p == 2*it + 2)    return {2'b00, 6'b100010, 1'b1};
        return 9'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            pos[i] = -1; e_n[i] = '0; e_d[i] = '0; e_q[i] = '0; e_done[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            e_done[i] = 1'b0;
            if (!reset) begin
                pos[i] = -1; e_n[i] = '0; e_d[i] = '0; e_q[i] = '0;
            end else if (pos[i] < 0) begin
                if (start) begin
                    pos[i] = 0; e_n[i] = n_in; e_d[i] = d_in;
                end
            end else if (abort) begin
                pos[i] = -1;
            end else if (pos[i] == 2*its[i] + 3) begin
                e_q[i] = q_in; e_done[i] = 1'b1; pos[i] = -1;
            end else begin
                pos[i]++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("N%0d", i), n_o[i], e_n[i]);
            chk($sformatf("D%0d", i), d_o[i], e_d[i]);
            chk($sformatf("ctrl%0d", i), {23'b0, c1_o[i], op_o[i], rm_o[i]},
                {23'b0, ctrl_exp(pos[i], its[i])});
            chk($sformatf("busy%0d", i), {31'b0, busy_o[i]}, {31'b0, pos[i] >= 0});
            chk($sformatf("done%0d", i), {31'b0, done_o[i]}, {31'b0, e_done[i]});
            chk($sformatf("qout%0d", i), q_o[i], e_q[i]);
        end
        if (done_o[0] === 1'b1) dq0.push_back(cyc);
        if (done_o[1] === 1'b1) dq1.push_back(cyc);
    endtask

    // One clock: inputs applied in the low phase, outputs checked at negedge.
    task automatic step(input logic s, input logic a, input logic [31:0] n, input logic [31:0] d);
        start = s; abort = a; n_in = n; d_in = d; q_in = $urandom;
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        chk_all();
    endtask

    task automatic idle(input int k);
        for (int j = 0; j < k; j++) step(1'b0, 1'b0, $urandom, $urandom);
    endtask

    initial begin
        int c0;
        int g;

        // reset state, including start ignored while reset is held
        model_reset();
        #3 chk_all();
        step(1'b1, 1'b0, $urandom, $urandom);
        reset = 1'b1;
        idle(1);

        // nominal divide; abort together with start in IDLE, start wins
        dq0.delete(); dq1.delete();
        c0 = cyc + 1;
        step(1'b1, 1'b1, 32'h4F951295, 32'h41E00002);
        idle(20);
        chk("ndone5", dq0.size(), 1);
        chk("lat5", (dq0.size() > 0) ? dq0[0] - c0 : -1, 14);
        chk("ndone1", dq1.size(), 1);
        chk("lat1", (dq1.size() > 0) ? dq1[0] - c0 : -1, 6);

        // start re-pulsed on cycle 5 of a divide is ignored
        dq0.delete(); dq1.delete();
        step(1'b1, 1'b0, 32'h3F800000, 32'h40400000);
        idle(3);
        step(1'b1, 1'b0, 32'hDEADBEEF, 32'h12345678);
        idle(20);
        chk("busy_start_ndone5", dq0.size(), 1);
        chk("busy_start_ndone1", dq1.size(), 1);

        // abort in the third MUL_A
        dq0.delete();
        step(1'b1, 1'b0, $urandom, $urandom);
        g = 0;
        while (pos[0] != 6 && g < 30) begin idle(1); g++; end
        step(1'b0, 1'b1, $urandom, $urandom);
        idle(20);
        chk("abort_ndone5", dq0.size(), 0);

        // asynchronous reset between edges during MUL_B
        step(1'b1, 1'b0, $urandom, $urandom);
        g = 0;
        while (pos[0] != 3 && g < 30) begin idle(1); g++; end
        #2 reset = 1'b0;
        #1 model_reset();
        chk_all();
        idle(1);
        reset = 1'b1;
        dq0.delete();
        c0 = cyc + 1;
        step(1'b1, 1'b0, $urandom, $urandom);
        idle(20);
        chk("post_reset_lat5", (dq0.size() > 0) ? dq0[0] - c0 : -1, 14);

        // start held high: back-to-back divides
        dq0.delete();
        for (int j = 0; j < 40; j++) step(1'b1, 1'b0, $urandom, $urandom);
        idle(20);
        chk("held_ndone5", dq0.size(), 3);
        for (int j = 1; j < dq0.size(); j++) chk("held_space5", dq0[j] - dq0[j-1], 15);

        // randomized traffic
        for (int j = 0; j < 400; j++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom, $urandom);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
